// File: rtl/pong_match_ctrl.sv
// Match-level sequencer for Pong: serve countdown, play, point pause and game over.
// Keeps both scores, chooses serve direction and gates the ball datapath.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 90,
  parameter int SCORE_W     = 4,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_reset,
  output logic               ball_en,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0]   POINT_CNT = CNT_W'(POINT_TICKS);
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);

  // Plain vector so the unused codes 5-7 are representable and recoverable.
  logic [2:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_1_q, score_1_d;
  logic [SCORE_W-1:0] score_2_q, score_2_d;
  logic [1:0]         winner_q, winner_d;
  logic               dir_q, dir_d;
  logic               start_q;
  logic               start_rise;
  logic               ball_reset_q, ball_en_q;

  assign start_rise = start & ~start_q;

  // {ball_reset, ball_en} for a given state; undefined codes look like IDLE.
  function automatic logic [1:0] decode(input logic [2:0] s);
    case (s)
      S_PLAY:  decode = 2'b01;
      S_POINT: decode = 2'b00;
      default: decode = 2'b10;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_1_d = score_1_q;
    score_2_d = score_2_q;
    winner_d  = winner_q;
    dir_d     = dir_q;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_rise) begin
          score_1_d = '0;
          score_2_d = '0;
          winner_d  = 2'b00;
          dir_d     = 1'b0;
          cnt_d     = SERVE_CNT;
          state_d   = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // Leaving PLAY on the first miss cycle guarantees one point per rally.
        if (miss_left || miss_right) begin
          state_d = S_POINT;
          cnt_d   = POINT_CNT;
          if (miss_left && !miss_right) begin
            score_2_d = score_2_q + 1'b1;
            dir_d     = 1'b1;
          end else if (miss_right && !miss_left) begin
            score_1_d = score_1_q + 1'b1;
            dir_d     = 1'b0;
          end
        end
      end
      S_POINT: begin
        if (tick) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            if (score_1_q == WIN_S) begin
              winner_d = 2'b01;
              state_d  = S_GAME_OVER;
            end else if (score_2_q == WIN_S) begin
              winner_d = 2'b10;
              state_d  = S_GAME_OVER;
            end else begin
              cnt_d   = SERVE_CNT;
              state_d = S_SERVE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      score_1_q    <= '0;
      score_2_q    <= '0;
      winner_q     <= 2'b00;
      dir_q        <= 1'b0;
      start_q      <= 1'b0;
      ball_reset_q <= 1'b1;
      ball_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_1_q    <= score_1_d;
      score_2_q    <= score_2_d;
      winner_q     <= winner_d;
      dir_q        <= dir_d;
      start_q      <= start;
      {ball_reset_q, ball_en_q} <= decode(state_d);
    end
  end

  assign state      = state_q;
  assign ball_reset = ball_reset_q;
  assign ball_en    = ball_en_q;
  assign serve_dir  = dir_q;
  assign score_1    = score_1_q;
  assign score_2    = score_2_q;
  assign winner     = winner_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with short serve/point timers and a tick every 4 clocks.
module tb_pong_match_ctrl;

  localparam int SCORE_W = 4;

  logic               clk;
  logic               reset;
  logic               tick;
  logic               start;
  logic               miss_left;
  logic               miss_right;
  logic               ball_reset;
  logic               ball_en;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_1;
  logic [SCORE_W-1:0] score_2;
  logic [1:0]         winner;
  logic [2:0]         state;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] ph    = '0;
  logic [2:0] exp_q[$];

  pong_match_ctrl #(
    .WIN_SCORE(2), .SERVE_TICKS(3), .POINT_TICKS(2), .SCORE_W(SCORE_W), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
    .ball_reset(ball_reset), .ball_en(ball_en), .serve_dir(serve_dir),
    .score_1(score_1), .score_2(score_2), .winner(winner), .state(state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; inputs move 1 time unit after the edge, tick is high one cycle in four.
  task automatic cyc();
    @(posedge clk);
    #1;
    ph   = ph + 8'd1;
    tick = (ph[1:0] == 2'd3);
  endtask

  // Advance past the next clock edge that sees tick high.
  task automatic tick_edge();
    int n = 0;
    while (!tick && n < 16) begin
      cyc();
      n++;
    end
    if (!tick) chk("tick_timeout", 32'd1, 32'd0);
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_edge();
  endtask

  task automatic miss(input logic l, input logic r);
    miss_left  = l;
    miss_right = r;
    cyc();
    miss_left  = 1'b0;
    miss_right = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_ball_reset", ball_reset, 1);
    chk("rst_ball_en", ball_en, 0);
    chk("rst_score_1", score_1, 0);
    chk("rst_score_2", score_2, 0);
    chk("rst_winner", winner, 0);
    chk("rst_dir", serve_dir, 0);
    repeat (20) cyc();
    chk("idle_state", state, 0);

    // start held high for the whole countdown must not restart it
    start = 1'b1;
    cyc();
    chk("start_state", state, 1);
    chk("serve_ball_reset", ball_reset, 1);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    for (int i = 0; i < 3; i++) begin
      logic [2:0] e;
      tick_edge();
      e = exp_q.pop_front();
      chk("serve_state", state, e);
      chk("serve_ball_en", ball_en, (e == 3'd2) ? 1 : 0);
    end
    repeat (5) cyc();
    chk("held_start_play", state, 2);
    start = 1'b0;

    // miss_right held across the whole pause: one point only
    miss_right = 1'b1;
    cyc();
    chk("pt1_state", state, 3);
    chk("pt1_score_1", score_1, 1);
    chk("pt1_dir", serve_dir, 0);
    chk("pt1_ball", {ball_reset, ball_en}, 0);
    tick_edge();
    chk("pt1_hold_state", state, 3);
    tick_edge();
    chk("pt1_serve", state, 1);
    chk("pt1_once", score_1, 1);
    repeat (2) cyc();
    miss_right = 1'b0;
    chk("pt1_serve_no_miss", score_1, 1);
    ticks(3);
    chk("play2", state, 2);

    miss(1'b1, 1'b0);
    chk("pt2_state", state, 3);
    chk("pt2_score_2", score_2, 1);
    chk("pt2_dir", serve_dir, 1);
    ticks(2);
    chk("pt2_serve", state, 1);
    ticks(3);

    // simultaneous miss is a replay
    miss(1'b1, 1'b1);
    chk("both_state", state, 3);
    chk("both_score_1", score_1, 1);
    chk("both_score_2", score_2, 1);
    chk("both_dir", serve_dir, 1);
    ticks(2);
    chk("both_serve", state, 1);
    ticks(3);

    // player 1 reaches WIN_SCORE
    miss(1'b0, 1'b1);
    chk("win_score_1", score_1, 2);
    chk("win_dir", serve_dir, 0);
    tick_edge();
    chk("win_point", state, 3);
    tick_edge();
    chk("go_state", state, 4);
    chk("go_winner", winner, 1);
    chk("go_ball", {ball_reset, ball_en}, 2'b10);
    miss_left = 1'b1;
    repeat (5) cyc();
    miss_left = 1'b0;
    chk("go_miss_ignored", score_2, 1);
    chk("go_hold", state, 4);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_s1", score_1, 0);
    chk("restart_s2", score_2, 0);
    chk("restart_winner", winner, 0);

    // build 1/1, then reset mid-PLAY
    ticks(3);
    miss(1'b0, 1'b1);
    ticks(5);
    miss(1'b1, 1'b0);
    ticks(5);
    chk("pre_rst_state", state, 2);
    chk("pre_rst_scores", {score_1, score_2}, 8'h11);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_scores", {score_1, score_2}, 0);
    chk("mid_rst_ball_en", ball_en, 0);

    // undefined state code recovers to IDLE
    force dut.state_q = 3'd6;
    #1;
    chk("forced_state", state, 6);
    release dut.state_q;
    cyc();
    chk("illegal_to_idle", state, 0);
    chk("illegal_ball_reset", ball_reset, 1);

    // start rising on a tick edge: counter loads, the tick is not counted
    begin
      int n = 0;
      while (!tick && n < 8) begin
        cyc();
        n++;
      end
    end
    chk("tick_aligned", tick, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("tick_start_state", state, 1);
    ticks(2);
    chk("tick_start_serve", state, 1);
    tick_edge();
    chk("tick_start_play", state, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match-level sequencer for the Pong datapath. It sits above the position block and drives the ball datapath:
- holds the ball centred during serve countdown and pauses, and enables ball motion only during play;
- consumes the left/right boundary-miss signals that position reports, keeps both scores, picks serve direction and declares the winner;
- runs on the game-rate tick, the same divided enable that advances paddles and ball.

Parameters:
WIN_SCORE, 7, score that ends the match (1..2^SCORE_W-1)
SERVE_TICKS, 60, ticks the ball is held centred before launch (>=1)
POINT_TICKS, 90, ticks of frozen pause after a point (>=1)
SCORE_W, 4, width of each score counter
CNT_W, 8, width of the tick down-counter (must hold max of SERVE_TICKS, POINT_TICKS)

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle game-rate enable pulse
start  in  1  start button level, already debounced
miss_left  in  1  ball passed player 1 (left) paddle; level, valid while asserted
miss_right  in  1  ball passed player 2 (right) paddle
ball_reset  out  1  force ball to screen centre
ball_en  out  1  allow ball position update
serve_dir  out  1  0 = launch toward right (player 2), 1 = toward left (player 1)
score_1  out  SCORE_W  player 1 score
score_2  out  SCORE_W  player 2 score
winner  out  2  00 none, 01 player 1, 10 player 2
state  out  3  current state code, for display/debug

Behaviour:
- Reset is synchronous, active-high, and overrides everything, including mid-play and mid-countdown. Next edge gives: state=IDLE, scores=0, winner=00, serve_dir=0, counter=0, start edge-detect register=0.
- start_rise = start & ~start_q, where start_q is registered every clk. Only the rising edge is acted on; a held button does nothing further.
- State codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4. Codes 5-7 go to IDLE on the next clk.
- Outputs are Moore, decoded from the state register and valid in the same cycle the state changes:
  - IDLE, SERVE, GAME_OVER: ball_reset=1, ball_en=0.
  - PLAY: ball_reset=0, ball_en=1.
  - POINT: ball_reset=0, ball_en=0 (ball frozen where it missed).
- IDLE: on start_rise, clear scores, set winner=00, set serve_dir=0, load counter=SERVE_TICKS, go to SERVE.
- SERVE: the counter decrements only on clk cycles with tick=1. On a tick while counter==1, go to PLAY. SERVE therefore lasts exactly SERVE_TICKS tick pulses. Miss inputs are ignored.
- PLAY: misses are sampled every clk, not gated by tick.
  - miss_left & ~miss_right: score_2+1, serve_dir=1, go to POINT.
  - miss_right & ~miss_left: score_1+1, serve_dir=0, go to POINT.
  - Both high in the same cycle: no score change, serve_dir unchanged, go to POINT (replay).
  - On entry to POINT, load counter=POINT_TICKS.
  - The score increment lands on the same edge as the PLAY->POINT transition. Only one point is awarded per PLAY visit, however long the miss input stays high.
- POINT: decrement on tick. On a tick while counter==1:
  - if score_1==WIN_SCORE, set winner=01 and go to GAME_OVER;
  - else if score_2==WIN_SCORE, set winner=10 and go to GAME_OVER;
  - else load counter=SERVE_TICKS and go to SERVE.
- GAME_OVER: scores and winner hold. On start_rise, clear scores, set winner=00, set serve_dir=0, load counter=SERVE_TICKS, go to SERVE.
- A start press in SERVE, PLAY or POINT is ignored.
- Scores never exceed WIN_SCORE and never wrap, because the match ends on reaching it.
- tick and start_rise in the same cycle in IDLE: the transition happens. The counter is loaded, not decremented, on that edge.

Test Plan:
Use SERVE_TICKS=3, POINT_TICKS=2, WIN_SCORE=2, tick every 4 clks.
- Reset then idle 20 clks: state=0, ball_reset=1, ball_en=0, scores 0/0, winner=00. start pulse: state=1 next clk.
- Serve countdown: after start, ball_en stays 0 through 2 ticks and goes to 1 on the edge of the 3rd tick, state=2. Hold start high throughout: no restart.
- Scoring: in PLAY, hold miss_right 10 clks: score_1=1 exactly once, serve_dir=0, state=3. After 2 ticks state=1. Then miss_left: score_2=1, serve_dir=1.
- Simultaneous miss_left and miss_right in PLAY: scores unchanged, state=3, then 1.
- Match end: take score_1 to 2. After POINT expires, state=4, winner=01, ball_reset=1. Misses are ignored. start clears to 0/0 with winner=00, state=1.
- Reset asserted mid-PLAY with score 1/1: next clk state=0, scores 0/0, ball_en=0. Also drive illegal state code 6 via force/release: state=0 next clk.
